// File: rtl/score_sequencer.sv
// score_sequencer
//
// Turns fishing-game events into a paced stream of single-cycle pulses for a
// downstream scorekeeper. Requests are banked in two saturating pending
// counters (increments and decrements). A small FSM drains them one pulse at a
// time, with GAP idle cycles forced after every pulse.
//
// Parameters
//   GAP       idle cycles forced after each inc/dec pulse (0..7)
//   MAX_PEND  saturation limit of each pending counter (<= 15)
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   catch_p      pulse, requests +1
//   big_catch_p  pulse, requests +3
//   miss_p       pulse, requests -1
//   new_game     pulse, clears score and all pending work (highest priority)
//   inc          registered one-cycle increment pulse
//   dec          registered one-cycle decrement pulse
//   rstScore     registered one-cycle score-clear pulse
//   busy         registered, high unless idle with nothing pending
//   ovf          registered sticky flag, a request was lost to saturation
//
// Optional feature
//   SCORE_FLOOR_EN  when defined, an 8-bit shadow copy of the score is kept and
//                   decrement requests served while it is zero are consumed
//                   silently, so the score never goes below zero.

module score_sequencer #(
    parameter int GAP      = 1,
    parameter int MAX_PEND = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic catch_p,
    input  logic big_catch_p,
    input  logic miss_p,
    input  logic new_game,
    output logic inc,
    output logic dec,
    output logic rstScore,
    output logic busy,
    output logic ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_CLEAR
    } state_t;

    localparam logic [4:0] MAX5     = 5'(MAX_PEND);
    localparam logic [3:0] MAX4     = 4'(MAX_PEND);
    localparam logic [2:0] GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    state_t     state, state_nx;
    logic [2:0] gap_cnt, gap_cnt_nx;
    logic [3:0] inc_pend, inc_pend_nx;
    logic [3:0] dec_pend, dec_pend_nx;
    logic       prefer_dec, prefer_dec_nx;
    logic       ovf_nx, inc_nx, dec_nx, rst_score_nx, busy_nx;

    logic [4:0] inc_sum, dec_sum;
    logic [3:0] inc_sat, dec_sat;
    logic       inc_clip, dec_clip;
    logic       have_work, contested, pick_dec, serve_slot, floor_hit;

`ifdef SCORE_FLOOR_EN
    logic [7:0] shadow, shadow_nx;
`endif

    // Next-state logic. Service decisions look only at the registered
    // counters, so a request is never served in the cycle it arrives.
    always_comb begin
        inc_sum  = {1'b0, inc_pend} + {4'd0, catch_p} + (big_catch_p ? 5'd3 : 5'd0);
        dec_sum  = {1'b0, dec_pend} + {4'd0, miss_p};
        inc_clip = (inc_sum > MAX5);
        dec_clip = (dec_sum > MAX5);
        inc_sat  = inc_clip ? MAX4 : inc_sum[3:0];
        dec_sat  = dec_clip ? MAX4 : dec_sum[3:0];

        have_work = (inc_pend != 4'd0) || (dec_pend != 4'd0);
        contested = (inc_pend != 4'd0) && (dec_pend != 4'd0);
        pick_dec  = contested ? prefer_dec : (dec_pend != 4'd0);

`ifdef SCORE_FLOOR_EN
        floor_hit = pick_dec && (shadow == 8'd0);
`else
        floor_hit = 1'b0;
`endif

        // A new pulse may start from IDLE, or directly at the end of the
        // spacing period so that back-to-back work keeps a GAP+1 cadence.
        serve_slot = have_work &&
                     ((state == S_IDLE) ||
                      ((state == S_PULSE) && (GAP == 0)) ||
                      ((state == S_GAP) && (gap_cnt == GAP_LAST)));

        state_nx      = state;
        gap_cnt_nx    = gap_cnt;
        inc_pend_nx   = inc_sat;
        dec_pend_nx   = dec_sat;
        prefer_dec_nx = prefer_dec;
        ovf_nx        = ovf | inc_clip | dec_clip;
        inc_nx        = 1'b0;
        dec_nx        = 1'b0;
        rst_score_nx  = 1'b0;
`ifdef SCORE_FLOOR_EN
        shadow_nx     = shadow;
`endif

        case (state)
            S_IDLE: state_nx = S_IDLE;
            S_PULSE: begin
                state_nx   = (GAP > 0) ? S_GAP : S_IDLE;
                gap_cnt_nx = 3'd0;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = S_IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt + 3'd1;
                end
            end
            S_CLEAR: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // The pointer only moves on contested serves, so the first contest
        // after reset always favours the increment side.
        if (serve_slot) begin
            if (contested) begin
                prefer_dec_nx = ~pick_dec;
            end
            if (pick_dec) begin
                dec_pend_nx = dec_sat - 4'd1;
                if (floor_hit) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_PULSE;
                    dec_nx   = 1'b1;
`ifdef SCORE_FLOOR_EN
                    shadow_nx = shadow - 8'd1;
`endif
                end
            end else begin
                inc_pend_nx = inc_sat - 4'd1;
                state_nx    = S_PULSE;
                inc_nx      = 1'b1;
`ifdef SCORE_FLOOR_EN
                shadow_nx   = (shadow == 8'hFF) ? shadow : shadow + 8'd1;
`endif
            end
        end

        // new_game overrides everything, including same-cycle requests.
        if (new_game) begin
            state_nx     = S_CLEAR;
            gap_cnt_nx   = 3'd0;
            inc_pend_nx  = 4'd0;
            dec_pend_nx  = 4'd0;
            ovf_nx       = 1'b0;
            inc_nx       = 1'b0;
            dec_nx       = 1'b0;
            rst_score_nx = 1'b1;
`ifdef SCORE_FLOOR_EN
            shadow_nx    = 8'd0;
`endif
        end

        busy_nx = (state_nx != S_IDLE) || (inc_pend_nx != 4'd0) || (dec_pend_nx != 4'd0);
    end

    // All state and every output are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            gap_cnt    <= 3'd0;
            inc_pend   <= 4'd0;
            dec_pend   <= 4'd0;
            prefer_dec <= 1'b0;
            ovf        <= 1'b0;
            inc        <= 1'b0;
            dec        <= 1'b0;
            rstScore   <= 1'b0;
            busy       <= 1'b0;
`ifdef SCORE_FLOOR_EN
            shadow     <= 8'd0;
`endif
        end else begin
            state      <= state_nx;
            gap_cnt    <= gap_cnt_nx;
            inc_pend   <= inc_pend_nx;
            dec_pend   <= dec_pend_nx;
            prefer_dec <= prefer_dec_nx;
            ovf        <= ovf_nx;
            inc        <= inc_nx;
            dec        <= dec_nx;
            rstScore   <= rst_score_nx;
            busy       <= busy_nx;
`ifdef SCORE_FLOOR_EN
            shadow     <= shadow_nx;
`endif
        end
    end

endmodule
